decode_stage: RTL

Registered, parametrised instruction-decode stage for the 16-bit custom processor, placed between the instruction register / fetch stage and register-file read + ALU. It splits each accepted instruction into register indices, immediate and jump target, and generates the PC, ALU-source, write-back, register-write and memory-write controls plus an illegal-opcode flag. It registers the result behind a valid/ready handshake. It inserts exactly one bubble on a load-use dependency, supports a synchronous flush, and counts hazard stall cycles.

---
 rtl/decode_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with valid/ready handshake, load-use bubble, flush and stall counter
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, instr is the incoming word
//   flush                 drop the held bundle and refuse input this cycle
//   out_valid/out_ready   downstream handshake for the decoded bundle
//   out_*                 registered fields and controls of the bundle
//   stall_cnt             saturating count of load-use stall cycles
module decode_stage #(
  parameter int IW   = 16,
  parameter int OPW  = 4,
  parameter int REGW = 3,
  parameter int IMMW = 6,
  parameter int JMPW = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_opcode,
  output logic [REGW-1:0] out_rd,
  output logic [REGW-1:0] out_rs1,
  output logic [REGW-1:0] out_rs2,
  output logic [IMMW-1:0] out_imm,
  output logic [JMPW-1:0] out_jump_addr,
  output logic            out_pc_sel,
  output logic            out_src2_sel,
  output logic            out_wb_sel,
  output logic            out_reg_we,
  output logic            out_mem_we,
  output logic            out_illegal,
  output logic [CNTW-1:0] stall_cnt
);
  logic [OPW-1:0]  op;
  logic [REGW-1:0] rd, rs1, rs2;
  logic            is_r, is_i, is_ld, is_st, is_j, is_ill;
  logic            rd_rd, rs1_rd, rs2_rd, hazard, accept;
  logic            valid_d, valid_q;
  logic [OPW-1:0]  opcode_d, opcode_q;
  logic [REGW-1:0] rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;
  logic [IMMW-1:0] imm_d, imm_q;
  logic [JMPW-1:0] jmp_d, jmp_q;
  logic            pc_sel_d, pc_sel_q, src2_d, src2_q, wb_d, wb_q;
  logic            reg_we_d, reg_we_q, mem_we_d, mem_we_q, ill_d, ill_q;
  logic [CNTW-1:0] cnt_d, cnt_q;

  always_comb begin
    op     = instr[OPW-1:0];
    rd     = instr[OPW+REGW-1:OPW];
    rs1    = instr[OPW+2*REGW-1:OPW+REGW];
    rs2    = instr[OPW+3*REGW-1:OPW+2*REGW];
    is_r   = op <= OPW'(4);
    is_i   = (op == OPW'(5)) | (op == OPW'(6));
    is_ld  = op == OPW'(7);
    is_st  = op == OPW'(8);
    is_j   = op == OPW'(9);
    is_ill = op >= OPW'(10);
    // the store data operand lives in the rd field
    rs1_rd = is_r | is_i | is_ld | is_st;
    rs2_rd = is_r;
    rd_rd  = is_st;
    hazard = in_valid & valid_q & wb_q &
             ((rs1_rd & (rs1 == rd_q)) | (rs2_rd & (rs2 == rd_q)) | (rd_rd & (rd == rd_q)));
    in_ready = (!valid_q | out_ready) & !hazard & !flush;
    accept   = in_valid & in_ready;
    // flush forces in_ready low, so it also blocks accept here
    valid_d  = accept | (valid_q & !out_ready & !flush);
    opcode_d = accept ? op : opcode_q;
    rd_d     = accept ? rd : rd_q;
    rs1_d    = accept ? rs1 : rs1_q;
    rs2_d    = accept ? rs2 : rs2_q;
    imm_d    = accept ? ((is_i | is_ld | is_st) ? instr[IW-1:IW-IMMW] : '0) : imm_q;
    jmp_d    = accept ? (is_j ? instr[OPW+JMPW-1:OPW] : '0) : jmp_q;
    pc_sel_d = accept ? is_j : pc_sel_q;
    src2_d   = accept ? (is_i | is_ld | is_st) : src2_q;
    wb_d     = accept ? is_ld : wb_q;
    reg_we_d = accept ? (is_r | is_i | is_ld) : reg_we_q;
    mem_we_d = accept ? is_st : mem_we_q;
    ill_d    = accept ? is_ill : ill_q;
    cnt_d    = (hazard & !flush & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      jmp_q    <= '0;
      pc_sel_q <= 1'b0;
      src2_q   <= 1'b0;
      wb_q     <= 1'b0;
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      jmp_q    <= jmp_d;
      pc_sel_q <= pc_sel_d;
      src2_q   <= src2_d;
      wb_q     <= wb_d;
      reg_we_q <= reg_we_d;
      mem_we_q <= mem_we_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_opcode    = opcode_q;
  assign out_rd        = rd_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_imm       = imm_q;
  assign out_jump_addr = jmp_q;
  assign out_pc_sel    = pc_sel_q;
  assign out_src2_sel  = src2_q;
  assign out_wb_sel    = wb_q;
  assign out_reg_we    = reg_we_q;
  assign out_mem_we    = mem_we_q;
  assign out_illegal   = ill_q;
  assign stall_cnt     = cnt_q;
endmodule
